// File: rtl/quad_enc_pkg.sv
// Shared encodings for the quadrature encoder counter: resolution select,
// FSM states and the {A,B} phase constants.
package quad_enc_pkg;
  localparam logic [1:0] RES_1X = 2'b00;
  localparam logic [1:0] RES_2X = 2'b01;
  localparam logic [1:0] RES_4X = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: flop-chain synchroniser followed by a stability filter.
// While i_init is high the filter follows the synchronised input directly.
module quad_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_init,
  input  logic i_raw,
  output logic o_synced,
  output logic o_filtered
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced   = r_sync[SYNC_STAGES-1];
  assign o_synced   = w_synced;
  assign o_filtered = r_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (i_init) begin
        r_filt <= w_synced;
        r_cnt  <= '0;
      end else if (w_synced == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= w_synced;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/quad_encoder_counter.sv
// Bounded quadrature position counter with 1x/2x/4x decode, saturate or wrap,
// parallel load, step/direction outputs and sticky illegal-transition flag.
module quad_encoder_counter
  import quad_enc_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int STEP            = 1,
  parameter int MIN_VAL         = 0,
  parameter int MAX_VAL         = (2**WIDTH) - 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       res_sel,
  input  logic             mode_wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             error_clr,
  output logic [WIDTH-1:0] value,
  output logic             dir,
  output logic             step_pulse,
  output logic             error
);
  localparam int EW = WIDTH + 1;
  localparam int IW = $clog2(SYNC_STAGES + 1);
  localparam logic [WIDTH:0] E_MIN  = EW'(MIN_VAL);
  localparam logic [WIDTH:0] E_MAX  = EW'(MAX_VAL);
  localparam logic [WIDTH:0] E_STEP = EW'(STEP);
  localparam logic [WIDTH:0] E_ONE  = EW'(1);
  localparam logic [IW-1:0]  INIT_LAST = IW'(SYNC_STAGES);

  state_t         r_state;
  logic [IW-1:0]  r_init_cnt;
  logic [1:0]     r_prev;
  logic           w_init, w_run;
  logic           w_sync_a, w_sync_b, w_filt_a, w_filt_b;
  logic [1:0]     w_ab, w_synced, w_diff;
  logic           w_up_tr, w_dn_tr, w_a_chg, w_illegal;
  logic           w_up, w_dn;
  logic [WIDTH:0] w_cur, w_sum, w_next, w_ld, w_ld_clamp;

  assign w_init = (r_state == ST_INIT);
  assign w_run  = (r_state == ST_RUN);

  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .i_init(w_init), .i_raw(a),
    .o_synced(w_sync_a), .o_filtered(w_filt_a)
  );
  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .i_init(w_init), .i_raw(b),
    .o_synced(w_sync_b), .o_filtered(w_filt_b)
  );

  assign w_ab      = {w_filt_a, w_filt_b};
  assign w_synced  = {w_sync_a, w_sync_b};
  assign w_diff    = r_prev ^ w_ab;
  assign w_a_chg   = (w_diff == 2'b10);
  assign w_illegal = w_run && (w_diff == 2'b11);
  assign w_up_tr   = ({r_prev, w_ab} == {AB_00, AB_10}) || ({r_prev, w_ab} == {AB_10, AB_11}) ||
                     ({r_prev, w_ab} == {AB_11, AB_01}) || ({r_prev, w_ab} == {AB_01, AB_00});
  assign w_dn_tr   = ({r_prev, w_ab} == {AB_00, AB_01}) || ({r_prev, w_ab} == {AB_01, AB_11}) ||
                     ({r_prev, w_ab} == {AB_11, AB_10}) || ({r_prev, w_ab} == {AB_10, AB_00});

  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    case (res_sel)
      RES_1X: begin
        w_up = ({r_prev, w_ab} == {AB_00, AB_10});
        w_dn = ({r_prev, w_ab} == {AB_10, AB_00});
      end
      RES_2X: begin
        w_up = w_up_tr && w_a_chg;
        w_dn = w_dn_tr && w_a_chg;
      end
      default: begin
        w_up = w_up_tr;
        w_dn = w_dn_tr;
      end
    endcase
    w_up = w_up && w_run;
    w_dn = w_dn && w_run;
  end

  // All bound arithmetic is one bit wider so value+STEP cannot overflow.
  always_comb begin
    w_cur  = {1'b0, value};
    w_sum  = w_cur + E_STEP;
    w_next = w_cur;
    if (w_up) begin
      if (w_sum > E_MAX) w_next = mode_wrap ? (E_MIN + (w_sum - E_MAX - E_ONE)) : E_MAX;
      else               w_next = w_sum;
    end else if (w_dn) begin
      if (w_cur < (E_MIN + E_STEP))
        w_next = mode_wrap ? (E_MAX - (E_MIN + E_STEP - w_cur - E_ONE)) : E_MIN;
      else
        w_next = w_cur - E_STEP;
    end
    w_ld       = {1'b0, load_value};
    w_ld_clamp = w_ld;
    if (w_ld < E_MIN)      w_ld_clamp = E_MIN;
    else if (w_ld > E_MAX) w_ld_clamp = E_MAX;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_prev     <= 2'b00;
      value      <= E_MIN[WIDTH-1:0];
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      error      <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (w_init) begin
        // prev takes the same value filtered is loading, so RUN starts with no phantom transition.
        r_prev <= w_synced;
        if (r_init_cnt == INIT_LAST) r_state <= ST_RUN;
        else                         r_init_cnt <= r_init_cnt + IW'(1);
      end else begin
        r_prev <= w_ab;
      end
      if (load) begin
        value <= w_ld_clamp[WIDTH-1:0];
      end else if ((w_up || w_dn) && (w_next != w_cur)) begin
        value      <= w_next[WIDTH-1:0];
        dir        <= w_up;
        step_pulse <= 1'b1;
      end
      if (w_illegal)      error <= 1'b1;
      else if (error_clr) error <= 1'b0;
    end
  end
endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
Parametrised quadrature rotary-encoder position counter for control inputs such as the colour-channel knobs. Raw A/B pins pass through a synchroniser and a per-channel debounce filter, then a 1x/2x/4x selectable decoder. The counter is bounded by MIN_VAL/MAX_VAL, with run-time saturate or wrap mode. Adds parallel load, direction/step outputs and illegal-transition detection.

Parameters:
WIDTH, 8, counter width in bits
STEP, 1, count change per qualified edge; must satisfy 1 <= STEP <= MAX_VAL-MIN_VAL
MIN_VAL, 0, lower bound of value
MAX_VAL, 2**WIDTH-1, upper bound of value; MIN_VAL < MAX_VAL
SYNC_STAGES, 2, synchroniser flops per input; >= 2
DEBOUNCE_CYCLES, 4, consecutive stable cycles before a filtered input changes; >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
a  in  1  raw encoder channel A, asynchronous
b  in  1  raw encoder channel B, asynchronous
res_sel  in  2  decode resolution: 00 = 1x, 01 = 2x, 10 = 4x, 11 = 4x
mode_wrap  in  1  1 = wrap at bounds, 0 = saturate
load  in  1  parallel load strobe
load_value  in  WIDTH  value to load
error_clr  in  1  clears error
value  out  WIDTH  current position
dir  out  1  direction of last count: 1 = up, 0 = down
step_pulse  out  1  one-cycle pulse when value changes due to a count
error  out  1  sticky illegal-transition flag

Behaviour:
- Reset (clk is the clock; reset is synchronous, active-high): value=MIN_VAL, dir=0, step_pulse=0, error=0. Sync flops, filtered, prev and debounce counters are 0. FSM enters INIT.
- Synchroniser: SYNC_STAGES flop chain per channel.
- Debounce, per channel: the counter increments while synced != filtered and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, filtered <= synced on the next edge and the counter clears.
- FSM INIT: lasts SYNC_STAGES+1 cycles after reset deasserts. filtered loads synced directly and prev <= filtered. No counting, no error. Then the FSM moves to RUN.
- FSM RUN: each cycle prev <= filtered {A,B}. A transition is a prev != filtered pair.
- Up sequence (A leads): 00→10→11→01→00. Down sequence: 00→01→11→10→00.
- 4x: every legal transition counts.
- 2x: only transitions where A changes count.
- 1x: up only on 00→10; down only on 10→00.
- Illegal transition (both bits change in one cycle): no count, error <= 1. prev still updates.
- error_clr clears error. If an illegal transition occurs in the same cycle as error_clr, set wins.
- Arithmetic uses a WIDTH+1-bit intermediate. Saturate mode: up gives min(value+STEP, MAX_VAL); down gives max(value-STEP, MIN_VAL).
- Wrap mode, up: if value+STEP > MAX_VAL then value <= MIN_VAL + (value+STEP-MAX_VAL-1). Down is symmetric: value <= MAX_VAL - (MIN_VAL-(value-STEP)-1).
- step_pulse=1 and dir updates only when value actually changes from a count. A saturated count does not pulse and does not update dir.
- Priority: reset > load > count. load sets value <= clamp(load_value, MIN_VAL, MAX_VAL), suppresses any count that cycle, and step_pulse=0. load is honoured in INIT.
- Latency: a raw edge that is stable from edge k appears in value at edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1. step_pulse is coincident with the value update.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles are ignored.
- res_sel and mode_wrap are sampled every cycle. Changing them mid-rotation takes effect on the next transition.
- Reset mid-operation aborts everything and re-enters INIT.

Decomposition:
- Package quad_enc_pkg: res_sel encodings (RES_1X, RES_2X, RES_4X), FSM state enum (ST_INIT, ST_RUN), A/B state constants (AB_00, AB_10, AB_11, AB_01).
- Sub-module quad_debounce: synchroniser plus debounce filter for one channel, parametrised by SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated twice.

Test Plan:
- Reset, then 4x, saturate, defaults. Drive 8 up-steps, each held 10 cycles → value=8, eight step_pulse, dir=1. Then 3 down-steps → value=5, dir=0.
- 1x, then 2x, then 4x. Drive one full up cycle 00→10→11→01→00 → value increments by 1, 2 and 4 respectively.
- Saturate with value=MAX_VAL (load 255), drive one up-step → value stays 255, no step_pulse. Set mode_wrap=1, one up-step → value=0, step_pulse=1. Down-step → 255.
- Parameters MIN_VAL=10, MAX_VAL=20, STEP=3, wrap, value=19. Up-step → 11. load_value=50 → value=20.
- Glitch of 2 cycles on A with DEBOUNCE_CYCLES=4 → no change. Simultaneous A and B toggle held stable → error=1, value unchanged. error_clr → error=0.
- Measure latency: single clean A rise at edge k → value updates at edge k+7 with defaults. Assert reset mid-rotation → value=0 and no count during INIT with inputs held at 11.
